serial_nibble_adder: RTL

Multi-cycle WIDTH-bit adder that computes `sum = a + b + cin` one 4-bit nibble per clock, least-significant nibble first. It uses a single 4-bit adder slice and a registered carry between nibbles. The block sits directly upstream of the 4-bit adder slice: it sequences operand nibbles and carry into the slice and collects the slice's sum and carry-out. Operands and result use a valid/ready handshake, so the block drops into a datapath in place of a wide combinational adder when area matters more than latency.

---
 rtl/serial_nibble_adder_pkg.sv | 17 +
 rtl/serial_nibble_adder_if.sv | 38 +++
 rtl/serial_nibble_add.sv | 26 ++
 rtl/serial_nibble_adder.sv | 125 ++++++++++++
 4 files changed

// File: rtl/serial_nibble_adder_pkg.sv
// Shared types and helpers for the serial nibble adder.
// Holds the nibble width, FSM state enum and counter sizing.
package serial_nibble_adder_pkg;

   localparam int NIBBLE_W = 4;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } sna_state_t;

   function automatic int cnt_w(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/serial_nibble_adder_if.sv
// Operand/result handshake bundle for the serial nibble adder.
// ovf is carried only when SNA_OVERFLOW_EN is defined.
interface serial_nibble_adder_if #(
   parameter int WIDTH = 16
);
   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic             cin;
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] sum;
   logic             cout;
`ifdef SNA_OVERFLOW_EN
   logic             ovf;

   modport master (
      output in_valid, a, b, cin, out_ready,
      input  in_ready, out_valid, sum, cout, ovf
   );

   modport slave (
      input  in_valid, a, b, cin, out_ready,
      output in_ready, out_valid, sum, cout, ovf
   );
`else
   modport master (
      output in_valid, a, b, cin, out_ready,
      input  in_ready, out_valid, sum, cout
   );

   modport slave (
      input  in_valid, a, b, cin, out_ready,
      output in_ready, out_valid, sum, cout
   );
`endif
endinterface

// File: rtl/serial_nibble_add.sv
// 4-bit combinational adder slice with carry in/out.
// Also exposes the carry into bit 3 for signed overflow detection.
module nibble_add
   import serial_nibble_adder_pkg::*;
(
   input  logic [NIBBLE_W-1:0] a,
   input  logic [NIBBLE_W-1:0] b,
   input  logic                ci,
   output logic [NIBBLE_W-1:0] s,
   output logic                co,
   output logic                c3
);

   logic [3:0] lo;
   logic [1:0] hi;

   // low three bits plus carry, then the top bit fed by c3
   always_comb begin
      lo = {1'b0, a[2:0]} + {1'b0, b[2:0]} + {3'b000, ci};
      c3 = lo[3];
      hi = {1'b0, a[3]} + {1'b0, b[3]} + {1'b0, c3};
      s  = {hi[0], lo[2:0]};
      co = hi[1];
   end

endmodule

// File: rtl/serial_nibble_adder.sv
// Multi-cycle WIDTH-bit adder, one nibble per clock, LSB nibble first.
// Optional macro SNA_OVERFLOW_EN adds the registered signed ovf output.
module serial_nibble_adder
   import serial_nibble_adder_pkg::*;
#(
   parameter int WIDTH = 16
) (
   input  logic                  clk,
   input  logic                  rst_n,
   serial_nibble_adder_if.slave  bus
);

   localparam int N  = WIDTH / NIBBLE_W;
   localparam int CW = cnt_w(N);
   localparam logic [CW-1:0] LAST = CW'(N - 1);

   sna_state_t state_q, state_d;

   logic [WIDTH-1:0] a_sr, b_sr, sum_sr;
   logic [CW-1:0]    cnt_q;
   logic             carry_q;

   logic [NIBBLE_W-1:0]       sl_s;
   logic                      sl_co;
   logic [WIDTH+NIBBLE_W-1:0] sum_cat;

   assign sum_cat = {sl_s, sum_sr};

`ifdef SNA_OVERFLOW_EN
   logic sl_c3;
   logic ovf_q;

   nibble_add u_slice (
      .a  (a_sr[NIBBLE_W-1:0]),
      .b  (b_sr[NIBBLE_W-1:0]),
      .ci (carry_q),
      .s  (sl_s),
      .co (sl_co),
      .c3 (sl_c3)
   );

   // overflow captured on the final (sign) nibble only
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         ovf_q <= 1'b0;
      else if (state_q == RUN && cnt_q == LAST)
         ovf_q <= sl_c3 ^ sl_co;
   end

   assign bus.ovf = ovf_q;
`else
   nibble_add u_slice (
      .a  (a_sr[NIBBLE_W-1:0]),
      .b  (b_sr[NIBBLE_W-1:0]),
      .ci (carry_q),
      .s  (sl_s),
      .co (sl_co),
      .c3 ()
   );
`endif

   // state register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         state_q <= IDLE;
      else
         state_q <= state_d;
   end

   // next-state logic
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         IDLE: if (bus.in_valid)   state_d = RUN;
         RUN:  if (cnt_q == LAST)  state_d = DONE;
         DONE: if (bus.out_ready)  state_d = IDLE;
         default:                  state_d = IDLE;
      endcase
   end

   // handshake outputs decoded from state only
   always_comb begin
      bus.in_ready  = 1'b0;
      bus.out_valid = 1'b0;
      unique case (state_q)
         IDLE:    bus.in_ready  = 1'b1;
         DONE:    bus.out_valid = 1'b1;
         default: ;
      endcase
   end

   // operand capture and nibble-serial datapath
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         a_sr    <= '0;
         b_sr    <= '0;
         sum_sr  <= '0;
         cnt_q   <= '0;
         carry_q <= 1'b0;
      end else begin
         unique case (state_q)
            IDLE: begin
               if (bus.in_valid) begin
                  a_sr    <= bus.a;
                  b_sr    <= bus.b;
                  carry_q <= bus.cin;
                  cnt_q   <= '0;
               end
            end
            RUN: begin
               a_sr    <= a_sr >> NIBBLE_W;
               b_sr    <= b_sr >> NIBBLE_W;
               sum_sr  <= sum_cat[WIDTH+NIBBLE_W-1:NIBBLE_W];
               carry_q <= sl_co;
               cnt_q   <= cnt_q + 1'b1;
            end
            default: ;
         endcase
      end
   end

   assign bus.sum  = sum_sr;
   assign bus.cout = carry_q;

endmodule
